// File: rtl/servo_slew.sv
// Slew-rate limiter feeding the RC servo pulse generator: walks pos toward a latched target by `rate` per tick.
// Optional macro SERVO_LIMIT_EN clamps written targets into POS_MIN..POS_MAX.
module servo_slew #(
  parameter int TICK_DIV  = 25000,
  parameter int RESET_POS = 128,
  parameter int POS_MIN   = 16,
  parameter int POS_MAX   = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] target,
  input  logic       target_we,
  input  logic [3:0] rate,
  output logic [7:0] pos,
  output logic       busy,
  output logic       done
);

  localparam int             CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]     RST_P    = 8'(RESET_POS);

  if (TICK_DIV < 2 || POS_MIN > POS_MAX) begin : g_bad_cfg
    $error("servo_slew: TICK_DIV must be >= 2 and POS_MIN <= POS_MAX");
  end

  typedef enum logic {IDLE, RAMP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [7:0]    tgt, tgt_n, tgt_in, pos_n;
  logic          busy_n, done_n;
  logic          up, retgt;
  logic [8:0]    diff;

  // Free-running divider; tick is registered so it lands exactly once per TICK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_LAST);
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

`ifdef SERVO_LIMIT_EN
  localparam logic [7:0] LO = 8'(POS_MIN);
  localparam logic [7:0] HI = 8'(POS_MAX);
  always_comb begin
    tgt_in = target;
    if (target < LO)      tgt_in = LO;
    else if (target > HI) tgt_in = HI;
  end
`else
  assign tgt_in = target;
`endif

  // Distance is taken in 9 bits so a far target can never wrap the comparison.
  assign up    = (tgt > pos);
  assign diff  = up ? ({1'b0, tgt} - {1'b0, pos}) : ({1'b0, pos} - {1'b0, tgt});
  assign retgt = target_we && (tgt_in != tgt);

  always_comb begin
    state_n = state;
    pos_n   = pos;
    done_n  = 1'b0;
    tgt_n   = target_we ? tgt_in : tgt;
    case (state)
      IDLE: begin
        if (tgt != pos) begin
          if (rate == 4'd0) begin
            // A write landing on the jump edge re-arms another jump, so done waits for that one.
            if (!done) begin
              pos_n  = tgt;
              done_n = !retgt;
            end
          end else begin
            state_n = RAMP;
          end
        end
      end
      RAMP: begin
        if (tick) begin
          if (rate == 4'd0 || diff <= {5'd0, rate}) begin
            pos_n = tgt;
            if (!retgt) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            pos_n = up ? pos + {4'd0, rate} : pos - {4'd0, rate};
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RAMP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pos   <= RST_P;
      tgt   <= RST_P;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      tgt   <= tgt_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_servo_slew.sv
// Scoreboard bench for servo_slew: every expected pos change is queued, a monitor pops on each observed change.
module tb_servo_slew;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] target = 8'd0;
  logic       target_we = 1'b0;
  logic [3:0] rate = 4'd0;
  logic [7:0] pos;
  logic       busy, done;

  servo_slew #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .target(target), .target_we(target_we),
    .rate(rate), .pos(pos), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pos;
    logic       done;
    logic       busy;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_pos = 8'd128;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [7:0] p, input logic d, input logic b);
    ev_t e;
    e.pos = p; e.done = d; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic write_tgt(input logic [7:0] t);
    target = t;
    target_we = 1'b1;
    @(negedge clk);
    target_we = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int lim);
    for (int i = 0; i < lim && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic back_to_centre();
    rate = 4'd0;
    expect_ev(8'd128, 1'b1, 1'b0);
    write_tgt(8'd128);
    wait_drain("centre", 20);
  endtask

  // Monitor: each change of pos must match the next queued event, done may only pulse with a change.
  always @(negedge clk) begin
    ev_t e;
    if (pos !== last_pos) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pos: got %0d want no change from %0d", pos, last_pos);
      end else begin
        e = exp_q.pop_front();
        check("ev_pos", pos, e.pos);
        check("ev_done", done, e.done);
        check("ev_busy", busy, e.busy);
      end
    end else if (done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL stray_done: got done=1 at pos %0d want 0", pos);
    end
    last_pos = pos;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  t0, t1, t2;
    bit  found;
    t0 = -1; t1 = -1; t2 = -1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pos", pos, 128);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Tick spacing
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dut.tick === 1'b1) begin
        if (t0 < 0) t0 = c;
        else if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
    end
    check("tick_period1", t1 - t0, 4);
    check("tick_period2", t2 - t1, 4);

    // Reset mid-ramp returns to centre with no done
    rate = 4'd4;
    expect_ev(8'd132, 1'b0, 1'b1);
    write_tgt(8'd200);
    wait_drain("pre_rst", 20);
    expect_ev(8'd128, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    wait_drain("midrst", 5);

    // rate=0 jump, two edges after strobe
    rate = 4'd0;
    expect_ev(8'd200, 1'b1, 1'b0);
    write_tgt(8'd200);
    check("jump_hold", pos, 128);
    @(negedge clk);
    check("jump_pos", pos, 200);
    check("jump_done", done, 1);
    check("jump_busy", busy, 0);
    @(negedge clk);
    check("jump_done_once", done, 0);
    wait_drain("jump", 5);

    // Ramp up at rate 10
    back_to_centre();
    rate = 4'd10;
    expect_ev(8'd138, 1'b0, 1'b1);
    expect_ev(8'd148, 1'b0, 1'b1);
    expect_ev(8'd150, 1'b1, 1'b0);
    write_tgt(8'd150);
    wait_drain("up10", 40);
    check("up10_busy_after", busy, 0);

    // Ramp down at rate 15 toward 5 without wrap
    back_to_centre();
    rate = 4'd15;
    expect_ev(8'd113, 1'b0, 1'b1);
    expect_ev(8'd98,  1'b0, 1'b1);
    expect_ev(8'd83,  1'b0, 1'b1);
    expect_ev(8'd68,  1'b0, 1'b1);
    expect_ev(8'd53,  1'b0, 1'b1);
    expect_ev(8'd38,  1'b0, 1'b1);
    expect_ev(8'd23,  1'b0, 1'b1);
`ifdef SERVO_LIMIT_EN
    expect_ev(8'd16,  1'b1, 1'b0);
`else
    expect_ev(8'd8,   1'b0, 1'b1);
    expect_ev(8'd5,   1'b1, 1'b0);
`endif
    write_tgt(8'd5);
    wait_drain("down15", 80);

    // Retarget mid-ramp reverses direction immediately
    back_to_centre();
    rate = 4'd4;
    expect_ev(8'd132, 1'b0, 1'b1);
    expect_ev(8'd136, 1'b0, 1'b1);
    expect_ev(8'd140, 1'b0, 1'b1);
    write_tgt(8'd250);
    wait_drain("retgt_up", 30);
    for (int p = 136; p > 100; p -= 4) expect_ev(8'(p), 1'b0, 1'b1);
    expect_ev(8'd100, 1'b1, 1'b0);
    write_tgt(8'd100);
    wait_drain("retgt_down", 80);

    // Write coincident with the landing tick: done suppressed, ramp continues
    rate = 4'd4;
    write_tgt(8'd102);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (busy === 1'b1 && dut.tick === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    check("coinc_found", int'(found), 1);
    expect_ev(8'd102, 1'b0, 1'b1);
    expect_ev(8'd106, 1'b0, 1'b1);
    expect_ev(8'd110, 1'b1, 1'b0);
    write_tgt(8'd110);
    wait_drain("coinc", 40);

    // Range ends
    rate = 4'd0;
`ifdef SERVO_LIMIT_EN
    expect_ev(8'd16, 1'b1, 1'b0);
`else
    expect_ev(8'd0, 1'b1, 1'b0);
`endif
    write_tgt(8'd0);
    wait_drain("low_end", 10);
    rate = 4'd15;
`ifdef SERVO_LIMIT_EN
    for (int k = 1; k <= 14; k++) expect_ev(8'(16 + 15 * k), 1'b0, 1'b1);
    expect_ev(8'd240, 1'b1, 1'b0);
`else
    for (int k = 1; k <= 16; k++) expect_ev(8'(15 * k), 1'b0, 1'b1);
    expect_ev(8'd255, 1'b1, 1'b0);
`endif
    write_tgt(8'd255);
    wait_drain("high_end", 120);
    check("final_busy", busy, 0);

    repeat (8) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
